// File: rtl/dec_syndrome.sv
// RS syndrome generator: Horner-accumulates RS_PAR_LEN syndromes over ENC_SYM_NUM symbols per beat.
// Optional registered all-zero flag on syn_zero when DEC_SYN_ZERO_FLAG_EN is defined.

module dec_syn_lane #(
  parameter int                 M    = 8,
  parameter logic [M-1:0]       POL  = 8'h1D,
  parameter int                 NUM  = 4,
  parameter int                 FIR  = 3,
  parameter int                 ROOT = 0
) (
  input  logic                  first,
  input  logic [NUM-1:0][M-1:0] sym,
  input  logic [M-1:0]          syn_q,
  output logic [M-1:0]          syn_nxt
);
  function automatic logic [M-1:0] xtime(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POL : '0);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    p = '0;
    for (int i = M-1; i >= 0; i--) begin
      p = xtime(p);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  function automatic logic [M-1:0] alpha_pow(input int e);
    logic [M-1:0] r;
    r = M'(1);
    for (int i = 0; i < e; i++) r = xtime(r);
    return r;
  endfunction

  localparam logic [M-1:0] ROOT_C = alpha_pow(ROOT);

  logic [M-1:0] s;

  // Beat 0 restarts from zero and only its low FIR lanes carry symbols.
  always_comb begin
    s = first ? '0 : syn_q;
    for (int k = NUM-1; k >= 0; k--)
      if (!first || k < FIR) s = gf_mul(s, ROOT_C) ^ sym[k];
    syn_nxt = s;
  end
endmodule

module dec_syndrome #(
  parameter int                       EGF_ORDER   = 8,
  parameter logic [EGF_ORDER-1:0]     EGF_PRI_POL = 8'h1D,
  parameter int                       RS_MES_LEN  = 239,
  parameter int                       RS_PAR_LEN  = 16,
  parameter int                       ENC_SYM_NUM = 4,
  parameter int                       RS_FCR      = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ENC_SYM_NUM*EGF_ORDER-1:0]    in_data,
  output logic                                syn_valid,
  input  logic                                syn_ready,
  output logic [RS_PAR_LEN*EGF_ORDER-1:0]     syn_data
`ifdef DEC_SYN_ZERO_FLAG_EN
  , output logic                              syn_zero
`endif
);
  localparam int N        = RS_MES_LEN + RS_PAR_LEN;
  localparam int BEAT_NUM = (N + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
  localparam int FIR_NUM  = (N % ENC_SYM_NUM == 0) ? ENC_SYM_NUM : N % ENC_SYM_NUM;
  localparam int CW       = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_NUM - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                                    state_q, state_d;
  logic [CW-1:0]                             cnt_q, cnt_d;
  logic [RS_PAR_LEN-1:0][EGF_ORDER-1:0]      syn_q, syn_d, syn_nxt;
  logic                                      syn_valid_q, syn_valid_d;
  logic [ENC_SYM_NUM-1:0][EGF_ORDER-1:0]     sym;
  logic                                      accept, first, last;

  assign sym       = in_data;
  assign in_ready  = (state_q == HOLD) ? syn_ready : 1'b1;
  assign accept    = in_valid & in_ready;
  assign first     = (cnt_q == '0);
  assign last      = (cnt_q == LAST);
  assign syn_valid = syn_valid_q;
  assign syn_data  = syn_q;

  for (genvar j = 0; j < RS_PAR_LEN; j++) begin : g_lane
    dec_syn_lane #(
      .M(EGF_ORDER), .POL(EGF_PRI_POL), .NUM(ENC_SYM_NUM), .FIR(FIR_NUM), .ROOT(j + RS_FCR)
    ) u_lane (
      .first(first), .sym(sym), .syn_q(syn_q[j]), .syn_nxt(syn_nxt[j])
    );
  end

  // In HOLD the counter has already wrapped, so an accepted beat is beat 0 of the next codeword.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    syn_d       = syn_q;
    syn_valid_d = syn_valid_q;
    if (accept) begin
      syn_d       = syn_nxt;
      cnt_d       = last ? '0 : cnt_q + CW'(1);
      state_d     = last ? HOLD : ACC;
      syn_valid_d = last;
    end else if (state_q == HOLD && syn_ready) begin
      state_d     = IDLE;
      syn_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
    end
  end

`ifdef DEC_SYN_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) syn_zero <= 1'b0;
    else     syn_zero <= ~|syn_d;
  end
`endif
endmodule

// File: tb/tb_dec_syndrome.sv
// Directed bench for dec_syndrome: zero/encoded codewords, single-symbol errors, reset, back-to-back.
// Codewords come from an LFSR systematic encoder; expected syndromes are hand-derived constants.

module tb_dec_syndrome;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, syn_valid, syn_ready;
  logic [31:0]  in_data;
  logic [127:0] syn_data;
`ifdef DEC_SYN_ZERO_FLAG_EN
  logic         syn_zero;
`endif

  dec_syndrome dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data)
`ifdef DEC_SYN_ZERO_FLAG_EN
    , .syn_zero(syn_zero)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] cw [255];
  logic [7:0] g  [17];

  localparam logic [127:0] ALL_ONE = {16{8'h01}};
  localparam logic [127:0] ALPHA_J = 128'h26_13_87_CD_E8_74_3A_1D_80_40_20_10_08_04_02_01;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa;
    r = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  task automatic build_gen();
    logic [7:0] a;
    for (int i = 0; i < 17; i++) g[i] = 8'h00;
    g[0] = 8'h01; a = 8'h01;
    for (int j = 0; j < 16; j++) begin
      for (int i = 16; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], a);
      g[0] = gmul(g[0], a);
      a = gmul(a, 8'h02);
    end
  endtask

  task automatic encode();
    logic [7:0] par [16];
    logic [7:0] fb;
    for (int i = 0; i < 16; i++) par[i] = 8'h00;
    for (int m = 0; m < 239; m++) begin
      cw[m] = 8'(m);
      fb = 8'(m) ^ par[15];
      for (int i = 15; i >= 1; i--) par[i] = par[i-1] ^ gmul(fb, g[i]);
      par[0] = gmul(fb, g[0]);
    end
    for (int k = 0; k < 16; k++) cw[239+k] = par[15-k];
  endtask

  function automatic logic [31:0] beat_data(input int b, input logic [7:0] junk);
    int i;
    if (b == 0) return {junk, cw[0], cw[1], cw[2]};
    i = 3 + 4*(b-1);
    return {cw[i], cw[i+1], cw[i+2], cw[i+3]};
  endfunction

  task automatic send_beat(input logic [31:0] d);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d;
    #1;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) chk("beat_accept_timeout", {127'b0, in_ready}, 128'h1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_cw_from(input int b0, input logic [7:0] junk, input bit gap);
    for (int b = b0; b < 64; b++) begin
      send_beat(beat_data(b, junk));
      if (b == 62) chk("valid_before_last", {127'b0, syn_valid}, 128'h0);
      if (gap && b == 10) repeat (3) @(negedge clk);
    end
    chk("valid_after_last", {127'b0, syn_valid}, 128'h1);
  endtask

  task automatic handshake();
    syn_ready = 1'b1;
    @(negedge clk);
    syn_ready = 1'b0;
    chk("valid_drop", {127'b0, syn_valid}, 128'h0);
  endtask

  task automatic chk_zero(input string tag, input logic e);
`ifdef DEC_SYN_ZERO_FLAG_EN
    chk(tag, {127'b0, syn_zero}, {127'b0, e});
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; syn_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {127'b0, syn_valid}, 128'h0);
    chk("rst_data", syn_data, 128'h0);
    chk_zero("rst_zero", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {127'b0, in_ready}, 128'h1);

    for (int i = 0; i < 255; i++) cw[i] = 8'h00;
    send_cw_from(0, 8'h00, 1'b1);
    chk("allzero_syn", syn_data, 128'h0);
    chk_zero("allzero_flag", 1'b1);
    handshake();

    build_gen();
    encode();
    send_cw_from(0, 8'h5A, 1'b0);
    chk("enc_syn", syn_data, 128'h0);
    chk_zero("enc_flag", 1'b1);
    handshake();

    cw[254] = cw[254] ^ 8'h01;
    send_cw_from(0, 8'h00, 1'b0);
    chk("err_last_syn", syn_data, ALL_ONE);
    chk_zero("err_last_flag", 1'b0);
    handshake();
    cw[254] = cw[254] ^ 8'h01;

    cw[253] = cw[253] ^ 8'h01;
    send_cw_from(0, 8'hFF, 1'b0);
    chk("err_pen_syn", syn_data, ALPHA_J);
    handshake();
    cw[253] = cw[253] ^ 8'h01;

    // Error on the very first symbol, with junk in the ignored top lane of beat 0.
    cw[0] = cw[0] ^ 8'h01;
    send_cw_from(0, 8'hA5, 1'b0);
    chk("err_first_syn", {104'b0, syn_data[23:0]}, {104'b0, 24'h47_8E_01});
    handshake();
    cw[0] = cw[0] ^ 8'h01;

    cw[254] = cw[254] ^ 8'h01;
    for (int b = 0; b < 20; b++) send_beat(beat_data(b, 8'h00));
    rst = 1'b1;
    #1;
    chk("midrst_valid", {127'b0, syn_valid}, 128'h0);
    chk("midrst_data", syn_data, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {127'b0, in_ready}, 128'h1);
    cw[254] = cw[254] ^ 8'h01;
    send_cw_from(0, 8'h00, 1'b0);
    chk("after_rst_syn", syn_data, 128'h0);
    handshake();

    cw[254] = cw[254] ^ 8'h01;
    send_cw_from(0, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", {127'b0, in_ready}, 128'h0);
      chk("stall_data", syn_data, ALL_ONE);
    end
    cw[254] = cw[254] ^ 8'h01;
    cw[253] = cw[253] ^ 8'h01;
    syn_ready = 1'b1; in_valid = 1'b1; in_data = beat_data(0, 8'h00);
    #1;
    chk("b2b_ready", {127'b0, in_ready}, 128'h1);
    @(negedge clk);
    syn_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_valid_low", {127'b0, syn_valid}, 128'h0);
    send_cw_from(1, 8'h00, 1'b0);
    chk("b2b_syn", syn_data, ALPHA_J);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
